// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths and the execute-stage state encoding.
`default_nettype none

package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int REG_AW = 3;
    localparam int SEL_W  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OPER = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/reg_file_8x16.sv
// reg_file_8x16: general register file with two operand read ports, a debug
// read port and one synchronous write port; synchronous active-low clear.
`default_nettype none

module reg_file_8x16 #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [AW-1:0]     raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] mem [NREGS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a  = mem[raddr_a];
    assign rdata_b  = mem[raddr_b];
    assign dbg_data = mem[dbg_addr];

endmodule

`default_nettype wire

// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: operand fetch, ALU settle wait and writeback around an
// external combinational ALU; also performs immediate register loads.
`default_nettype none

module alu_exec_ctrl #(
    parameter int DATA_W     = cpu_pkg::DATA_W,
    parameter int NREGS      = 8,
    parameter int SETTLE_CYC = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_imm_en,
    input  logic [cpu_pkg::SEL_W-1:0] cmd_sel,
    input  logic [$clog2(NREGS)-1:0]  cmd_rd,
    input  logic [$clog2(NREGS)-1:0]  cmd_rs,
    input  logic [$clog2(NREGS)-1:0]  cmd_rt,
    input  logic [DATA_W-1:0]         cmd_imm,
    output logic [DATA_W-1:0]         alu_a,
    output logic [DATA_W-1:0]         alu_b,
    output logic [cpu_pkg::SEL_W-1:0] alu_sel,
    input  logic [DATA_W-1:0]         alu_result,
    input  logic                      alu_carry,
    output logic                      done,
    output logic                      flag_c,
    output logic                      flag_z,
    input  logic [$clog2(NREGS)-1:0]  dbg_addr,
    output logic [DATA_W-1:0]         dbg_data
);

    import cpu_pkg::*;

    localparam int AW = $clog2(NREGS);

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        settle_cnt;
    logic              accept;
    logic              imm_en_q;
    logic [SEL_W-1:0]  sel_q;
    logic [AW-1:0]     rd_q;
    logic [AW-1:0]     rs_q;
    logic [AW-1:0]     rt_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] res_q;
    logic              carry_q;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              wb_we;
    logic [DATA_W-1:0] wb_data;

    assign cmd_ready = (state == IDLE) && rst_n;
    assign accept    = cmd_valid && cmd_ready;
    assign wb_we     = (state == WB);
    assign wb_data   = imm_en_q ? imm_q : res_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = cmd_imm_en ? WB : OPER;
            OPER:    state_nxt = EXEC;
            EXEC:    if (settle_cnt == 4'd0) state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            imm_en_q   <= 1'b0;
            sel_q      <= '0;
            rd_q       <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            imm_q      <= '0;
            res_q      <= '0;
            carry_q    <= 1'b0;
            settle_cnt <= 4'd0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= '0;
            flag_c     <= 1'b0;
            flag_z     <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        imm_en_q <= cmd_imm_en;
                        sel_q    <= cmd_sel;
                        rd_q     <= cmd_rd;
                        rs_q     <= cmd_rs;
                        rt_q     <= cmd_rt;
                        imm_q    <= cmd_imm;
                    end
                end
                OPER: begin
                    alu_a      <= rs_data;
                    alu_b      <= rt_data;
                    alu_sel    <= sel_q;
                    settle_cnt <= 4'(SETTLE_CYC - 1);
                end
                EXEC: begin
                    if (settle_cnt != 4'd0) begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end else begin
                        res_q   <= alu_result;
                        carry_q <= alu_carry;
                    end
                end
                WB: begin
                    // Immediate loads leave the flags untouched.
                    if (!imm_en_q) begin
                        flag_c <= carry_q;
                        flag_z <= (res_q == '0);
                    end
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    reg_file_8x16 #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .AW     (AW)
    ) u_regs (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (wb_we),
        .waddr    (rd_q),
        .wdata    (wb_data),
        .raddr_a  (rs_q),
        .rdata_a  (rs_data),
        .raddr_b  (rt_q),
        .rdata_b  (rt_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

endmodule

`default_nettype wire

// File: doc/alu_exec_ctrl.md
Name: alu_exec_ctrl

Overview:
- Operand-fetch and writeback stage wrapped around the combinational 16-bit ALU.
- Holds the 8 x 16-bit general register file.
- Accepts one command at a time, drives ALU A/B/Sel from registered operands, waits for settle, then writes ALU_Out to the destination register and updates the carry/zero flags.
- Also supports an immediate-load command that bypasses the ALU.

Parameters:
- DATA_W, 16, datapath width; must match the ALU width.
- NREGS, 8, register count; register address width is log2(NREGS) = 3.
- SETTLE_CYC, 1, cycles the ALU inputs are held stable before the result is sampled; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command this cycle
- cmd_imm_en  in  1  1 = immediate load; 0 = ALU operation
- cmd_sel  in  3  ALU operation select, passed to the ALU
- cmd_rd  in  3  destination register
- cmd_rs  in  3  source register for ALU A
- cmd_rt  in  3  source register for ALU B
- cmd_imm  in  16  immediate data
- alu_a  out  16  to ALU A
- alu_b  out  16  to ALU B
- alu_sel  out  3  to ALU ALU_Sel
- alu_result  in  16  from ALU ALU_Out
- alu_carry  in  1  from ALU CarryOut
- done  out  1  one-cycle pulse when writeback completes
- flag_c  out  1  carry flag
- flag_z  out  1  zero flag
- dbg_addr  in  3  debug read address
- dbg_data  out  16  combinational read of regfile[dbg_addr]

Behaviour:
- Reset (rst_n low at a rising edge) sets:
  - state to IDLE
  - all registers to 0x0000
  - alu_a, alu_b to 0x0000 and alu_sel to 3'b000
  - flag_c = 0, flag_z = 0, done = 0
  - the settle counter to 0
- Reset wins over every other event. A reset mid-operation abandons the command with no register write.
- cmd_ready = 1 only in IDLE and only while rst_n is high. A command is accepted on a rising edge where cmd_valid and cmd_ready are both 1. cmd_valid while busy is ignored; there is no queuing.
- Fields latched at accept: sel, rd, rs, rt, imm, imm_en.
- State machine:
  - IDLE: wait for accept. If imm_en, go to WB. Otherwise go to OPER.
  - OPER: alu_a <= reg[rs], alu_b <= reg[rt], alu_sel <= sel, counter <= SETTLE_CYC-1; go to EXEC. Operands are read in this cycle, so a result written by the previous command is visible.
  - EXEC: alu_a, alu_b and alu_sel are held. While counter != 0, decrement it. When counter == 0, capture alu_result and alu_carry into internal registers and go to WB.
  - WB:
    - Immediate path: reg[rd] <= imm. flag_c and flag_z are unchanged.
    - ALU path: reg[rd] <= captured result; flag_c <= captured carry; flag_z <= (captured result == 0).
    - In both paths: done = 1 for this cycle only; go to IDLE.
- Latency, counted from the accept edge to the edge at which done is asserted:
  - ALU command: SETTLE_CYC + 2 cycles; 3 at the default.
  - Immediate command: 1 cycle.
  - A new command may be accepted on the cycle after done, giving a back-to-back rate of one ALU command per SETTLE_CYC + 3 cycles.
- rd == rs or rd == rt is legal; sources are read in OPER before the WB write.
- Every register is writable; there is no hard-wired zero register.
- Outside OPER and EXEC, alu_a, alu_b and alu_sel retain their last values; they are not cleared.
- dbg_data is combinational from the current register state. A WB write becomes visible the cycle after the WB edge.

Decomposition:
- Shared package cpu_pkg:
  - DATA_W and REG_AW = 3
  - state enum {IDLE, OPER, EXEC, WB}
  - ALU select width constant (3)
- Natural sub-module: reg_file_8x16
  - two combinational read ports plus one debug read port
  - one synchronous write port
  - synchronous active-low clear
- The FSM, settle counter and flag registers stay in alu_exec_ctrl.

Test Plan:
- Bench ALU stub: sel 000 returns A+B with carry-out; all other sel values return A&B with carry 0.
- Reset: hold rst_n low for 2 clocks with cmd_valid = 1 -> every dbg read returns 0x0000, flag_c = 0, flag_z = 0, cmd_ready stays 0 while in reset and goes to 1 on the first cycle after release.
- Immediate loads: imm R1 = 0xE03F, then R2 = 0x7F80 -> done one cycle after each accept, dbg R1 = 0xE03F, dbg R2 = 0x7F80, flags unchanged.
- Add with carry: sel 000, rd = 3, rs = 1, rt = 2 (R1 = 0xE03F, R2 = 0x7F80) -> alu_a = 0xE03F and alu_b = 0x7F80 stable through EXEC; done exactly 3 cycles after accept; R3 = 0x5FBF; flag_c = 1; flag_z = 0.
- Zero result and aliasing: sel 001, rd = 1, rs = 1, rt = 4 (R1 = 0xE03F, R4 = 0x0000) -> R1 = 0x0000, flag_z = 1, flag_c = 0.
- Busy: cmd_valid held high with differing fields during OPER and EXEC -> cmd_ready = 0, those commands are dropped, and the next command is accepted only on the cycle after done.
- Reset mid-op: assert rst_n low during EXEC of an ALU command to R5 -> no done pulse, R5 = 0x0000, block returns to IDLE with all outputs at reset values.
